// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared branch encodings, compare constants and condition resolver
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        NOTBRANCH    = 2'b00,
        UNCONDBRANCH = 2'b01,
        CONDBRANCH   = 2'b10
    } branch_flag_e;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    // cmp_flags = {ltu, lt, eq}
    localparam int CMP_EQ_BIT  = 0;
    localparam int CMP_LT_BIT  = 1;
    localparam int CMP_LTU_BIT = 2;

    localparam logic [1:0] WEAK_NT = 2'b01;

    typedef struct packed {
        logic valid;
        logic taken;
    } cond_result_t;

    // Unknown funct3 values resolve as an invalid, not-taken condition.
    function automatic cond_result_t resolve_cond(input logic [2:0] mode, input logic [2:0] flags);
        cond_result_t r;
        r.valid = 1'b1;
        r.taken = 1'b0;
        case (mode)
            FUNCT3_BEQ:  r.taken = flags[CMP_EQ_BIT];
            FUNCT3_BNE:  r.taken = ~flags[CMP_EQ_BIT];
            FUNCT3_BLT:  r.taken = flags[CMP_LT_BIT];
            FUNCT3_BGE:  r.taken = ~flags[CMP_LT_BIT];
            FUNCT3_BLTU: r.taken = flags[CMP_LTU_BIT];
            FUNCT3_BGEU: r.taken = ~flags[CMP_LTU_BIT];
            default:     r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - prediction, resolution and statistics bus of the branch unit
interface branch_predict_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
);
    logic                  rdy_in;
    logic [ADDR_WIDTH-1:0] pred_pc;
    logic                  pred_taken;
    logic                  res_valid;
    logic [ADDR_WIDTH-1:0] res_pc;
    logic [1:0]            branch_flag;
    logic [2:0]            cond_mode;
    logic [2:0]            cmp_flags;
    logic                  res_pred_taken;
    logic                  actual_taken;
    logic                  flush_out;
    logic [CNT_WIDTH-1:0]  branch_cnt;
    logic [CNT_WIDTH-1:0]  miss_cnt;

    // master: pipeline side (fetch + EX); slave: the branch unit
    modport master (
        output rdy_in, pred_pc, res_valid, res_pc, branch_flag, cond_mode, cmp_flags, res_pred_taken,
        input  pred_taken, actual_taken, flush_out, branch_cnt, miss_cnt
    );

    modport slave (
        input  rdy_in, pred_pc, res_valid, res_pc, branch_flag, cond_mode, cmp_flags, res_pred_taken,
        output pred_taken, actual_taken, flush_out, branch_cnt, miss_cnt
    );

endinterface

// File: rtl/branch_predict_unit_bht_counter_array.sv
// rtl/branch_predict_unit_bht_counter_array.sv - table of 2-bit saturating counters, 1 comb read, 1 sync update
module bht_counter_array
    import branch_predict_unit_pkg::*;
#(
    parameter int BHT_IDX_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BHT_IDX_WIDTH-1:0] rd_idx,
    output logic [1:0]               rd_cnt,
    input  logic                     we,
    input  logic [BHT_IDX_WIDTH-1:0] wr_idx,
    input  logic                     wr_taken
);
    localparam int ENTRIES = 1 << BHT_IDX_WIDTH;

    logic [1:0] cnt_q [ENTRIES];

    // No bypass: a same-cycle read of the written entry returns the old value.
    assign rd_cnt = cnt_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= WEAK_NT;
            end
        end else if (we) begin
            if (wr_taken && cnt_q[wr_idx] != 2'b11) begin
                cnt_q[wr_idx] <= cnt_q[wr_idx] + 2'b01;
            end else if (!wr_taken && cnt_q[wr_idx] != 2'b00) begin
                cnt_q[wr_idx] <= cnt_q[wr_idx] - 2'b01;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - branch resolver, bimodal predictor, mispredict flush and statistics
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int BHT_IDX_WIDTH = 6,
    parameter int CNT_WIDTH     = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_unit_if.slave bus
);
    logic [1:0] rd_cnt;
    logic       accept;
    logic       counted;
    logic       outcome;
    logic       train;
    logic       mispredict;
    cond_result_t cond;

    // rst is not folded in here: the reset branch of every register has priority.
    assign accept = bus.res_valid & bus.rdy_in;

    always_comb begin
        counted = 1'b0;
        outcome = 1'b0;
        train   = 1'b0;
        cond    = resolve_cond(bus.cond_mode, bus.cmp_flags);
        case (bus.branch_flag)
            UNCONDBRANCH: begin
                counted = 1'b1;
                outcome = 1'b1;
            end
            CONDBRANCH: begin
                counted = cond.valid;
                outcome = cond.valid & cond.taken;
                train   = cond.valid;
            end
            default: ;
        endcase
    end

    assign mispredict = counted & (outcome != bus.res_pred_taken);

    bht_counter_array #(.BHT_IDX_WIDTH(BHT_IDX_WIDTH)) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (bus.pred_pc[BHT_IDX_WIDTH+1:2]),
        .rd_cnt   (rd_cnt),
        .we       (accept & train),
        .wr_idx   (bus.res_pc[BHT_IDX_WIDTH+1:2]),
        .wr_taken (outcome)
    );

    assign bus.pred_taken = rd_cnt[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.actual_taken <= 1'b0;
            bus.flush_out    <= 1'b0;
            bus.branch_cnt   <= '0;
            bus.miss_cnt     <= '0;
        end else if (bus.rdy_in) begin
            if (bus.res_valid) begin
                bus.actual_taken <= outcome;
                bus.flush_out    <= mispredict;
                if (counted && bus.branch_cnt != '1) begin
                    bus.branch_cnt <= bus.branch_cnt + 1'b1;
                end
                if (mispredict && bus.miss_cnt != '1) begin
                    bus.miss_cnt <= bus.miss_cnt + 1'b1;
                end
            end else begin
                bus.flush_out <= 1'b0;
            end
        end
    end

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.pred_pc[ADDR_WIDTH-1:BHT_IDX_WIDTH+2], bus.pred_pc[1:0],
                              bus.res_pc[ADDR_WIDTH-1:BHT_IDX_WIDTH+2], bus.res_pc[1:0], rd_cnt[0]};

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised branch resolver and predictor. It is the next generation of the single-flag branch controller. It indexes a table of 2-bit saturating counters to give the fetch stage a taken/not-taken prediction. It resolves all six RV32I conditional compare modes from ALU flags. It trains the table and raises a registered one-cycle mispredict flush back to fetch/issue. It sits between the EX-stage ALU and the IF-stage PC selector.

## Interface
Parameters:
- ADDR_WIDTH, 32: PC width.
- BHT_IDX_WIDTH, 6: log2 of table entries (64 entries).
- CNT_WIDTH, 32: width of the statistics counters.

Ports:
- clk, input, 1: sole clock; all state changes on its rising edge.
- rst, input, 1: reset, synchronous and active-high.
- rdy_in, input, 1: global ready; low freezes all state.
- pred_pc, input, ADDR_WIDTH: PC of the instruction being fetched.
- pred_taken, output, 1: prediction for pred_pc, combinational from table.
- res_valid, input, 1: an EX-stage resolution is presented this cycle.
- res_pc, input, ADDR_WIDTH: PC of the resolving instruction.
- branch_flag, input, 2: `NOTBRANCH / `UNCONDBRANCH / `CONDBRANCH.
- cond_mode, input, 3: funct3 (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- cmp_flags, input, 3: {ltu, lt, eq} from ALU compare of rs1 vs rs2.
- res_pred_taken, input, 1: prediction carried down the pipe with the instruction.
- actual_taken, output, 1: registered resolved outcome.
- flush_out, output, 1: registered one-cycle mispredict pulse.
- branch_cnt, output, CNT_WIDTH: resolved branches (conditional + unconditional).
- miss_cnt, output, CNT_WIDTH: mispredicted branches.

## Operation
- Index: idx = pc[BHT_IDX_WIDTH+1:2] for both ports.
- Entry: 2-bit counter, 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- pred_taken = counter[idx(pred_pc)][1].
- A resolution is accepted when res_valid & rdy_in & !rst.
- Outcome by branch_flag:
  - NOTBRANCH: outcome not taken; no table update, no counting, flush_out 0.
  - UNCONDBRANCH: outcome taken; table untouched; branch_cnt increments.
  - CONDBRANCH: outcome depends on cond_mode:
    - BEQ: eq.
    - BNE: !eq.
    - BLT: lt.
    - BGE: !lt.
    - BLTU: ltu.
    - BGEU: !ltu.
    - Other funct3 values: not taken, no update, no count.
    - Valid modes train the counter: +1 if taken, −1 if not, saturating at 11 and 00. branch_cnt increments.
- Mispredict = counted branch & (outcome != res_pred_taken). It increments miss_cnt and sets flush_out.
- Statistics counters saturate at all-ones and never wrap.

## Timing
- Prediction latency is 0 cycles (combinational read). There is no write-to-read bypass: a predict of the same index in the accept cycle sees the pre-update value.
- Resolution latency is 1 cycle. actual_taken, flush_out, the counter update and the statistics update all take effect on the edge after accept.
- flush_out is high for exactly one cycle per mispredict. With back-to-back accepted mispredicts it stays high continuously.
- Cycle with no accept and rdy_in high: flush_out becomes 0 and actual_taken holds.
- rdy_in low: every register holds, including flush_out, and no update occurs.
- Reset, synchronous: all counters → 01, pred_taken reads 0, actual_taken 0, flush_out 0, branch_cnt 0, miss_cnt 0.
- Reset asserted in the accept cycle: reset wins and the resolution is discarded.
- A one-cycle reset pulse fully restores the reset state.

## Structure
- Add to the shared defines:
  - the branch_flag encodings (the existing ones);
  - the cond_mode funct3 constants;
  - the cmp_flags bit positions;
  - the counter reset value WEAK_NT = 2'b01.
- Sub-module bht_counter_array (parameter BHT_IDX_WIDTH):
  - one combinational read port;
  - one synchronous saturating-update port (we, idx, taken);
  - synchronous reset.
- Condition decode, the mispredict register and the statistics counters stay in the top module.

## Test plan
- Reset then read any pred_pc: pred_taken=0. After three taken BEQ resolutions with eq=1 at pc 0x100, pred_pc=0x100 → pred_taken=1, and 0x104 stays 0.
- Saturation: five taken resolutions then one not-taken at pc 0x40 → entry 10, pred_taken still 1. Two more not-taken → 00, pred 0.
- Each of the six modes, with cmp_flags 3'b110 and 3'b001 and res_pred_taken=0:
  - actual_taken matches the mode table;
  - flush_out pulses exactly when taken;
  - invalid funct3 010 → no flush, counters unchanged.
- UNCONDBRANCH with res_pred_taken=0 → flush_out=1 next cycle, branch_cnt=1, miss_cnt=1, table entry still 01.
- rdy_in low across a would-be accept → nothing changes. A mispredict followed by rdy_in low for 3 cycles → flush_out held high for those cycles, then drops.
- Aliasing and same-cycle behaviour:
  - pc 0x000 and 0x100 (BHT_IDX_WIDTH=6) share entry 0.
  - Predict-in-accept-cycle returns the old value.
  - rst asserted during an accept → all outputs 0 and the entry stays 01.
